// File: rtl/sequential_divider.sv
// Multi-cycle signed radix-2 restoring divider with a start/busy/done handshake.
// Optional unsigned operation is enabled by defining SEQ_DIVIDER_UNSIGNED_OP_EN.
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_OP_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           r_state,     w_state_next;
    logic [CW-1:0]    r_count,     w_count_next;
    logic [WIDTH-1:0] r_rem,       w_rem_next;
    logic [WIDTH-1:0] r_quo,       w_quo_next;
    logic [WIDTH-1:0] r_div_mag,   w_div_mag_next;
    logic             r_neg_q,     w_neg_q_next;
    logic             r_neg_r,     w_neg_r_next;
    logic             r_zero,      w_zero_next;
    logic [WIDTH-1:0] r_quotient,  w_quotient_next;
    logic [WIDTH-1:0] r_remainder, w_remainder_next;
    logic             r_busy,      w_busy_next;
    logic             r_done,      w_done_next;
    logic             r_dbz,       w_dbz_next;

    logic             w_signed_op;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

`ifdef SEQ_DIVIDER_UNSIGNED_OP_EN
    assign w_signed_op = ~op_unsigned;
`else
    assign w_signed_op = 1'b1;
`endif

    // |MIN| = 2^(WIDTH-1) is exactly representable as an unsigned magnitude.
    assign w_dvd_neg = w_signed_op & dividend[WIDTH-1];
    assign w_dvs_neg = w_signed_op & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

    // Partial remainder is always below the divisor, so the shifted value fits
    // in WIDTH+1 bits and the borrow bit of the trial subtraction is the compare.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div_mag};
    assign w_ge    = ~w_diff[WIDTH];

    // NOTE: every next-value is defaulted to its register first, so no path
    // through this block can leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_rem_next       = r_rem;
        w_quo_next       = r_quo;
        w_div_mag_next   = r_div_mag;
        w_neg_q_next     = r_neg_q;
        w_neg_r_next     = r_neg_r;
        w_zero_next      = r_zero;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_busy_next      = r_busy;
        w_done_next      = r_done;
        w_dbz_next       = r_dbz;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_neg_q_next   = w_dvd_neg ^ w_dvs_neg;
                    w_neg_r_next   = w_dvd_neg;
                    w_div_mag_next = w_dvs_mag;
                    w_quo_next     = w_dvd_mag;
                    w_count_next   = CW'(WIDTH);
                    w_busy_next    = 1'b1;
                    w_done_next    = 1'b0;
                    w_dbz_next     = 1'b0;
                    if (divisor == '0) begin
                        // Park |dividend| in rem so FIX restores the dividend as remainder.
                        w_zero_next  = 1'b1;
                        w_rem_next   = w_dvd_mag;
                        w_state_next = FIX;
                    end else begin
                        w_zero_next  = 1'b0;
                        w_rem_next   = '0;
                        w_state_next = CALC;
                    end
                end
            end

            CALC: begin
                w_rem_next   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                w_quo_next   = {r_quo[WIDTH-2:0], w_ge};
                w_count_next = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_next = FIX;
                end
            end

            FIX: begin
                w_quotient_next  = r_zero  ? '1      : (r_neg_q ? -r_quo : r_quo);
                w_remainder_next = r_neg_r ? -r_rem  : r_rem;
                w_dbz_next       = r_zero;
                w_done_next      = 1'b1;
                w_busy_next      = 1'b0;
                w_state_next     = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div_mag   <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_rem       <= w_rem_next;
            r_quo       <= w_quo_next;
            r_div_mag   <= w_div_mag_next;
            r_neg_q     <= w_neg_q_next;
            r_neg_r     <= w_neg_r_next;
            r_zero      <= w_zero_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_dbz       <= w_dbz_next;
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
